// File: rtl/sdram_init_monitor.sv
// SDRAM init-sequence monitor: decodes the command bus and checks the
// power-up/init order and timing. Optional macro: SDRAM_MON_MODE_CHECK_EN.
module sdram_init_monitor #(
  parameter int          SDRAM_ADDR_WIDTH = 12,
  parameter int          SDRAM_BANK_WIDTH = 2,
  parameter int          T_POWERUP        = 5000,
  parameter int          T_RP             = 2,
  parameter int          T_RFC            = 7,
  parameter int          T_MRD            = 2,
  parameter int          AREF_NUM         = 2,
  parameter logic [11:0] EXP_MODE         = 12'h032
) (
  input  logic                        Sys_clk,
  input  logic                        Rst,
  input  logic [3:0]                  Cmd_bus,
  input  logic [SDRAM_ADDR_WIDTH-1:0] A_addr,
  input  logic [SDRAM_BANK_WIDTH-1:0] Bank_addr,
  input  logic                        Init_done_in,
  output logic [2:0]                  Mon_cmd,
  output logic [3:0]                  Aref_cnt,
  output logic [2:0]                  Mode_cas_lat,
  output logic [2:0]                  Mode_burst_len,
  output logic                        Init_ok,
  output logic                        Init_err,
  output logic [2:0]                  Err_code
);

  localparam logic [2:0] C_NOP  = 3'd0;
  localparam logic [2:0] C_PRE  = 3'd1;
  localparam logic [2:0] C_AREF = 3'd2;
  localparam logic [2:0] C_LMR  = 3'd3;
  localparam logic [2:0] C_ACT  = 3'd4;
  localparam logic [2:0] C_RW   = 3'd5;
  localparam logic [2:0] C_BST  = 3'd6;

  localparam int TMAX0 = (T_RP > T_RFC) ? T_RP : T_RFC;
  localparam int TMAX  = (TMAX0 > T_MRD) ? TMAX0 : T_MRD;
  localparam int TW    = (TMAX > 1) ? $clog2(TMAX + 1) : 1;
  localparam int PW    = (T_POWERUP > 1) ? $clog2(T_POWERUP + 1) : 1;

  typedef enum logic [2:0] {
    S_PWR,
    S_TRP,
    S_AREF,
    S_TRFC,
    S_TMRD,
    S_DONE,
    S_ERR
  } state_t;

  state_t          r_state;
  logic [TW-1:0]   r_timer;
  logic [PW-1:0]   r_pwr_cnt;
  logic [2:0]      r_mon_cmd;
  logic [3:0]      r_aref_cnt;
  logic [2:0]      r_cas;
  logic [2:0]      r_bl;
  logic            r_init_ok;
  logic            r_init_err;
  logic [2:0]      r_err_code;

  logic [2:0]      w_cmd;
  logic            w_nop;
  logic            w_err7;
  logic            w_tmr_last;
  logic            w_aref_few;
  logic [11:0]     w_mode;
  logic            w_mode_bad;
  logic            w_unused;

  assign w_unused = ^{A_addr, Bank_addr};
  assign w_mode   = 12'(A_addr);

  // Decode the sampled command; deselect reads as NOP.
  always_comb begin
    w_cmd = C_NOP;
    if (!Cmd_bus[3]) begin
      case (Cmd_bus[2:0])
        3'b111:  w_cmd = C_NOP;
        3'b010:  w_cmd = C_PRE;
        3'b001:  w_cmd = C_AREF;
        3'b000:  w_cmd = C_LMR;
        3'b011:  w_cmd = C_ACT;
        3'b101:  w_cmd = C_RW;
        3'b100:  w_cmd = C_RW;
        3'b110:  w_cmd = C_BST;
        default: w_cmd = C_NOP;
      endcase
    end
  end

  assign w_nop      = (w_cmd == C_NOP);
  assign w_err7     = Init_done_in || (w_cmd == C_ACT) ||
                      (w_cmd == C_RW) || (w_cmd == C_BST);
  assign w_tmr_last = (r_timer <= TW'(1));
  assign w_aref_few = (int'(r_aref_cnt) < AREF_NUM);

`ifdef SDRAM_MON_MODE_CHECK_EN
  assign w_mode_bad = (w_mode != EXP_MODE) || (Bank_addr != '0);
`else
  assign w_mode_bad = 1'b0 & (^w_mode) & (^EXP_MODE);
`endif

  // Init-sequence FSM with registered outputs; first error is sticky.
  always_ff @(posedge Sys_clk) begin
    if (Rst) begin
      r_state    <= S_PWR;
      r_timer    <= '0;
      r_pwr_cnt  <= '0;
      r_mon_cmd  <= C_NOP;
      r_aref_cnt <= '0;
      r_cas      <= '0;
      r_bl       <= '0;
      r_init_ok  <= 1'b0;
      r_init_err <= 1'b0;
      r_err_code <= '0;
    end else begin
      r_mon_cmd <= w_cmd;
      if ((w_cmd == C_AREF) && (r_aref_cnt != 4'hF))
        r_aref_cnt <= r_aref_cnt + 4'd1;

      case (r_state)
        S_PWR: begin
          if (w_err7) begin
            r_state    <= S_ERR;
            r_init_err <= 1'b1;
            r_err_code <= 3'd7;
          end else if (w_nop) begin
            if (int'(r_pwr_cnt) < T_POWERUP)
              r_pwr_cnt <= r_pwr_cnt + PW'(1);
          end else if ((int'(r_pwr_cnt) < T_POWERUP) ||
                       (w_cmd != C_PRE)) begin
            r_state    <= S_ERR;
            r_init_err <= 1'b1;
            r_err_code <= 3'd1;
          end else if (!A_addr[10]) begin
            r_state    <= S_ERR;
            r_init_err <= 1'b1;
            r_err_code <= 3'd2;
          end else begin
            r_state <= (T_RP > 1) ? S_TRP : S_AREF;
            r_timer <= TW'(T_RP - 1);
          end
        end

        S_TRP: begin
          if (w_err7) begin
            r_state    <= S_ERR;
            r_init_err <= 1'b1;
            r_err_code <= 3'd7;
          end else if (!w_nop) begin
            r_state    <= S_ERR;
            r_init_err <= 1'b1;
            r_err_code <= 3'd3;
          end else if (w_tmr_last) begin
            r_state <= S_AREF;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end

        S_AREF: begin
          if (w_err7) begin
            r_state    <= S_ERR;
            r_init_err <= 1'b1;
            r_err_code <= 3'd7;
          end else if (w_cmd == C_AREF) begin
            r_state <= (T_RFC > 1) ? S_TRFC : S_AREF;
            r_timer <= TW'(T_RFC - 1);
          end else if (w_cmd == C_PRE) begin
            if (!A_addr[10]) begin
              r_state    <= S_ERR;
              r_init_err <= 1'b1;
              r_err_code <= 3'd2;
            end else begin
              r_state <= (T_RP > 1) ? S_TRP : S_AREF;
              r_timer <= TW'(T_RP - 1);
            end
          end else if ((w_cmd == C_LMR) && !w_aref_few) begin
            if (w_mode_bad) begin
              r_state    <= S_ERR;
              r_init_err <= 1'b1;
              r_err_code <= 3'd6;
            end else begin
              r_cas   <= A_addr[6:4];
              r_bl    <= A_addr[2:0];
              r_state <= (T_MRD > 1) ? S_TMRD : S_DONE;
              r_timer <= TW'(T_MRD - 1);
            end
          end else if (!w_nop) begin
            r_state    <= S_ERR;
            r_init_err <= 1'b1;
            r_err_code <= 3'd4;
          end
        end

        S_TRFC: begin
          if (w_err7) begin
            r_state    <= S_ERR;
            r_init_err <= 1'b1;
            r_err_code <= 3'd7;
          end else if (!w_nop) begin
            r_state    <= S_ERR;
            r_init_err <= 1'b1;
            r_err_code <= 3'd4;
          end else if (w_tmr_last) begin
            r_state <= S_AREF;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end

        S_TMRD: begin
          if (w_err7) begin
            r_state    <= S_ERR;
            r_init_err <= 1'b1;
            r_err_code <= 3'd7;
          end else if (!w_nop) begin
            r_state    <= S_ERR;
            r_init_err <= 1'b1;
            r_err_code <= 3'd5;
          end else if (w_tmr_last) begin
            r_state <= S_DONE;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end

        S_DONE: r_init_ok <= 1'b1;

        S_ERR: r_init_ok <= 1'b0;

        default: r_state <= S_ERR;
      endcase
    end
  end

  assign Mon_cmd        = r_mon_cmd;
  assign Aref_cnt       = r_aref_cnt;
  assign Mode_cas_lat   = r_cas;
  assign Mode_burst_len = r_bl;
  assign Init_ok        = r_init_ok;
  assign Init_err       = r_init_err;
  assign Err_code       = r_err_code;

endmodule

// File: doc/sdram_init_monitor.md
Name: sdram_init_monitor

Overview:
- Responder-side checker for the SDRAM command bus driven by the SDRAM init controller.
- Samples {CS_N,RAS_N,CAS_N,WE_N}, A and BA every Sys_clk rising edge and decodes each command.
- Tracks the power-up/init sequence and timing: power-up wait, PRECHARGE ALL, AUTO REFRESH ×N, LOAD MODE REGISTER, tMRD.
- Flags the first protocol violation with a sticky error code and captures the programmed mode register. Sits beside the SDRAM pins in simulation and on-chip debug builds.

Parameters:
SDRAM_ADDR_WIDTH, 12, A bus width (≥11)
SDRAM_BANK_WIDTH, 2, BA bus width
T_POWERUP, 5000, min NOP/DESELECT cycles after reset release before first command (100 us @ 50 MHz)
T_RP, 2, cycles from PRECHARGE to next command
T_RFC, 7, cycles from AUTO REFRESH to next command
T_MRD, 2, cycles from LMR to init-complete
AREF_NUM, 2, min AUTO REFRESH count before LMR
EXP_MODE, 12'h032, expected A[11:0] at LMR (CL=3, BL=4, sequential)

Ports:
Sys_clk  in  1  clock
Rst  in  1  synchronous reset, active-high
Cmd_bus  in  4  {CS_N,RAS_N,CAS_N,WE_N}
A_addr  in  SDRAM_ADDR_WIDTH  SDRAM A bus
Bank_addr  in  SDRAM_BANK_WIDTH  SDRAM BA bus
Init_done_in  in  1  controller's INIT_DONE
Mon_cmd  out  3  decoded command, registered
Aref_cnt  out  4  AUTO REFRESHes seen (saturates at 15)
Mode_cas_lat  out  3  captured A[6:4]
Mode_burst_len  out  3  captured A[2:0]
Init_ok  out  1  sequence complete, no error
Init_err  out  1  sticky error
Err_code  out  3  first error cause

Behaviour:
- Single clock domain: Sys_clk. Reset is synchronous and active-high on Rst.
- All outputs are 0 during and after reset until updated.
- Decode (CS_N=1 → DESELECT, treated as NOP):
  - 0111 NOP=0
  - 0010 PRE=1
  - 0001 AREF=2
  - 0000 LMR=3
  - 0011 ACT=4
  - 0101/0100 RD/WR=5
  - 0110 BST=6
- Mon_cmd has 1-cycle latency.
- Timing rule: for a command sampled at cycle n with spacing T, any non-NOP at n+k, k<T, is an error. k≥T is legal.
- The timer is a down-counter loaded with T-1 on the command cycle.
- FSM:
  - PWR: count NOP cycles from the first cycle after Rst deasserts. Non-NOP before T_POWERUP counted → err 1. PRE at count ≥ T_POWERUP → TRP.
  - TRP: PRE requires A[10]=1, else err 2 (checked on entry). Non-NOP during tRP → err 3. Timer expiry → AREF.
  - AREF:
    - AREF → TRFC and Aref_cnt+1.
    - LMR with Aref_cnt ≥ AREF_NUM → capture mode fields, go to TMRD.
    - LMR with too few AREFs → err 4.
    - PRE → TRP, repeated precharge allowed.
    - Any other command → err 4.
  - TRFC: non-NOP before expiry → err 4. Expiry → AREF.
  - TMRD: non-NOP before expiry → err 5. Expiry → DONE, Init_ok=1 on the following cycle.
  - DONE: later commands only update Mon_cmd and Aref_cnt.
  - ERR: Init_err=1 and Err_code latched. Terminal until Rst; the first error wins.
- Err 7 cases:
  - ACT, RD/WR or BST in any state before DONE.
  - Init_done_in=1 in any state before DONE.
- Simultaneous violations in one cycle use priority 7 > 1..6.
- Rst asserted mid-sequence: returns to PWR, clears counters, captured mode and flags. No partial state survives.
- Aref_cnt saturates at 15 and does not wrap.

Optional Feature:
- Macro: SDRAM_MON_MODE_CHECK_EN.
  - Defined: at LMR, A[11:0] ≠ EXP_MODE → err 6 instead of TMRD; BA must be 0, else err 6.
  - Undefined: any mode value accepted and captured; err 6 is never produced.

Test Plan:
- Nominal sequence (reset, 5000 NOP, PRE A10=1, NOP×1, AREF, NOP×6, AREF, NOP×6, LMR A=12'h032, NOP×1, Init_done_in=1) → Init_ok=1 two cycles after LMR, Init_err=0, Aref_cnt=2, Mode_cas_lat=3, Mode_burst_len=2.
- PRE at cycle 4999 after reset release → Init_err=1, Err_code=1, Init_ok stays 0.
- AREF issued 3 cycles after previous AREF → Err_code=4. PRE with A10=0 → Err_code=2.
- LMR after a single AREF → Err_code=4. With SDRAM_MON_MODE_CHECK_EN, LMR A=12'h022 → Err_code=6; without the macro → Init_ok=1, Mode_cas_lat=2.
- Init_done_in=1 while in TRFC together with a premature AREF → Err_code=7 (priority).
- Rst pulsed mid-TRFC, then full nominal sequence replayed → Init_ok=1, Err_code=0, Aref_cnt=2.
